biquad_mac_sequencer: RTL

- Sequences one Direct-Form-I biquad IIR computation per input sample over a single shared multiplier.
- Drives the 4-bit filter select into the coefficient register and consumes its five registered coefficients (a1, a2, b0, b1, b2; signed Q4.20, 25 bits).
- Keeps the x/y history, accumulates five products per sample and saturates the result.
- Sits between the sample-rate strobe generator and the audio output path.

---
 rtl/biquad_mac_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/biquad_mac_sequencer.sv
// Direct-Form-I biquad sequencer: one IIR output per sample tick, computed over
// five cycles on a single shared multiplier.
//   clk, reset        : clock and synchronous active-high reset
//   sel_in            : requested filter select
//   sample_tick, x_in : one-cycle input strobe with its sample
//   a1, a2, b0, b1, b2: registered coefficients (signed Q4.20) for sel_out
//   sel_out           : select driven to the coefficient register
//   y_out, y_valid    : saturated result, pulse on update
//   busy              : high outside IDLE
//   sat_flag          : sticky, a result was clamped
//   missed_tick       : sticky, a sample tick was dropped
module biquad_mac_sequencer #(
  parameter int unsigned N     = 25,
  parameter int unsigned FRAC  = 20,
  parameter int unsigned GUARD = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   sel_in,
  input  logic         sample_tick,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] a2,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] b1,
  input  logic [N-1:0] b2,
  output logic [3:0]   sel_out,
  output logic [N-1:0] y_out,
  output logic         y_valid,
  output logic         busy,
  output logic         sat_flag,
  output logic         missed_tick
);

  localparam int unsigned AW = N + GUARD;

  typedef enum logic [1:0] {StIdle, StReload, StMac, StDone} state_e;

  state_e               state_q;
  logic [3:0]           sel_q;
  logic signed [N-1:0]  xq_q, x1_q, x2_q, y1_q, y2_q;
  logic signed [AW-1:0] acc_q;
  logic [2:0]           k_q;
  logic                 reload_cnt_q;
  logic [N-1:0]         y_out_q;
  logic                 y_valid_q, sat_q, missed_q;

  logic signed [N-1:0]   coef, operand;
  logic                  subtract;
  logic signed [2*N-1:0] prod;
  logic signed [AW-1:0]  term, acc_next;
  logic [GUARD:0]        acc_top;
  logic                  in_range;
  logic signed [N-1:0]   y_sat;

  // Operand mux for the shared multiplier; feedback terms are subtracted.
  always_comb begin
    coef     = '0;
    operand  = '0;
    subtract = 1'b0;
    unique case (k_q)
      3'd0: begin coef = b0; operand = xq_q; end
      3'd1: begin coef = b1; operand = x1_q; end
      3'd2: begin coef = b2; operand = x2_q; end
      3'd3: begin coef = a1; operand = y1_q; subtract = 1'b1; end
      3'd4: begin coef = a2; operand = y2_q; subtract = 1'b1; end
      default: ;
    endcase
    prod     = coef * operand;
    // Arithmetic shift truncates toward -inf before narrowing to accumulator width.
    term     = AW'(prod >>> FRAC);
    acc_next = subtract ? acc_q - term : acc_q + term;

    // In range when all bits from the result sign bit upward agree.
    acc_top  = acc_q[AW-1:N-1];
    in_range = (&acc_top) | ~(|acc_top);
    if (in_range) begin
      y_sat = acc_q[N-1:0];
    end else if (acc_q[AW-1]) begin
      y_sat = {1'b1, {(N-1){1'b0}}};
    end else begin
      y_sat = {1'b0, {(N-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      xq_q         <= '0;
      x1_q         <= '0;
      x2_q         <= '0;
      y1_q         <= '0;
      y2_q         <= '0;
      acc_q        <= '0;
      k_q          <= '0;
      reload_cnt_q <= 1'b0;
      y_out_q      <= '0;
      y_valid_q    <= 1'b0;
      sat_q        <= 1'b0;
      missed_q     <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // A select change wins over a coincident tick, which is then lost.
          if (sel_in != sel_q) begin
            state_q      <= StReload;
            sel_q        <= sel_in;
            x1_q         <= '0;
            x2_q         <= '0;
            y1_q         <= '0;
            y2_q         <= '0;
            reload_cnt_q <= 1'b0;
            if (sample_tick) missed_q <= 1'b1;
          end else if (sample_tick) begin
            state_q <= StMac;
            xq_q    <= x_in;
            acc_q   <= '0;
            k_q     <= '0;
          end
        end
        StReload: begin
          // Two cycles cover the coefficient register's one-cycle latency.
          if (sample_tick) missed_q <= 1'b1;
          if (reload_cnt_q) state_q <= StIdle;
          else reload_cnt_q <= 1'b1;
        end
        StMac: begin
          if (sample_tick) missed_q <= 1'b1;
          acc_q <= acc_next;
          if (k_q == 3'd4) state_q <= StDone;
          else k_q <= k_q + 3'd1;
        end
        StDone: begin
          if (sample_tick) missed_q <= 1'b1;
          y_out_q   <= y_sat;
          y_valid_q <= 1'b1;
          if (!in_range) sat_q <= 1'b1;
          x2_q      <= x1_q;
          x1_q      <= xq_q;
          y2_q      <= y1_q;
          y1_q      <= y_sat;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sel_out     = sel_q;
  assign y_out       = y_out_q;
  assign y_valid     = y_valid_q;
  assign busy        = (state_q != StIdle);
  assign sat_flag    = sat_q;
  assign missed_tick = missed_q;

endmodule
